// File: rtl/exc_pc_ctrl_pkg.sv
// Shared constants for the exception/PC-source controller: PC mux codes, CP0 map, ExcCodes, FSM.
package exc_pc_ctrl_pkg;

    localparam int unsigned IRQ_W     = 6;
    // Exception vector word address (byte 0x00004180); the PC mux hardcodes it.
    localparam logic [29:0] VEC_WADDR = 30'h0000_1060;

    typedef enum logic [2:0] {
        PC_NORMAL = 3'd0,
        PC_ADD    = 3'd1,
        PC_J      = 3'd2,
        PC_JR     = 3'd3,
        PC_EPC    = 3'd4,
        PC_ERROR  = 3'd5
    } pc_src_e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;
    localparam logic [4:0] EXC_RI  = 5'd10;
    localparam logic [4:0] EXC_OV  = 5'd12;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } state_e;

endpackage

// File: rtl/exc_pc_ctrl_cp0_regs.sv
// CP0 Status/Cause/EPC storage and mfc0 read mux.
// Optional EXC_BD_EN adds the delay-slot input and the Cause.BD bit.
module exc_pc_ctrl_cp0_regs
    import exc_pc_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IRQ_W-1:0] int_req_i,
    input  logic             wr_en_i,
    input  logic [4:0]       addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             exc_take_i,
    input  logic [4:0]       exc_code_i,
    input  logic [29:0]      exc_pc_i,
`ifdef EXC_BD_EN
    input  logic             in_delay_slot_i,
`endif
    input  logic             eret_i,
    output logic [31:0]      rdata_o,
    output logic             ie_o,
    output logic             exl_o,
    output logic [IRQ_W-1:0] im_o,
    output logic [IRQ_W-1:0] ip_o,
    output logic [29:0]      epc_o
);

    logic             ie_q, ie_d;
    logic             exl_q, exl_d;
    logic [IRQ_W-1:0] im_q, im_d;
    logic [IRQ_W-1:0] ip_q;
    logic [4:0]       code_q, code_d;
    logic [29:0]      epc_q, epc_d;
    logic             bd_q, bd_d;

    always_comb begin
        ie_d   = ie_q;
        exl_d  = exl_q;
        im_d   = im_q;
        code_d = code_q;
        epc_d  = epc_q;
        bd_d   = bd_q;
        if (wr_en_i) begin
            case (addr_i)
                CP0_STATUS: begin
                    ie_d  = wdata_i[0];
                    exl_d = wdata_i[1];
                    im_d  = wdata_i[15:10];
                end
                CP0_CAUSE: code_d = wdata_i[6:2];
                CP0_EPC:   epc_d  = wdata_i[31:2];
                default: ;
            endcase
        end
        // Exception fields override a simultaneous mtc0; EPC is frozen while nested.
        if (exc_take_i) begin
            exl_d  = 1'b1;
            code_d = exc_code_i;
`ifdef EXC_BD_EN
            bd_d = ~exl_q & in_delay_slot_i;
            if (!exl_q) begin
                epc_d = in_delay_slot_i ? exc_pc_i - 30'd1 : exc_pc_i;
            end
`else
            bd_d = 1'b0;
            if (!exl_q) begin
                epc_d = exc_pc_i;
            end
`endif
        end else if (eret_i) begin
            exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ie_q   <= 1'b0;
            exl_q  <= 1'b0;
            im_q   <= '0;
            ip_q   <= '0;
            code_q <= '0;
            epc_q  <= '0;
            bd_q   <= 1'b0;
        end else begin
            ie_q   <= ie_d;
            exl_q  <= exl_d;
            im_q   <= im_d;
            ip_q   <= int_req_i;
            code_q <= code_d;
            epc_q  <= epc_d;
            bd_q   <= bd_d;
        end
    end

    always_comb begin
        rdata_o = 32'h0;
        case (addr_i)
            CP0_STATUS: rdata_o = {16'h0, im_q, 8'h0, exl_q, ie_q};
            CP0_CAUSE:  rdata_o = {bd_q, 15'h0, ip_q, 3'h0, code_q, 2'h0};
            CP0_EPC:    rdata_o = {epc_q, 2'b00};
            default:    rdata_o = 32'h0;
        endcase
    end

    assign ie_o  = ie_q;
    assign exl_o = exl_q;
    assign im_o  = im_q;
    assign ip_o  = ip_q;
    assign epc_o = epc_q;

endmodule

// File: rtl/exc_pc_ctrl.sv
// PC-source arbitration, exception/interrupt entry, eret and pipeline flush control.
// Optional EXC_BD_EN adds in_delay_slot_i for branch-delay-slot exception handling.
module exc_pc_ctrl
    import exc_pc_ctrl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic             is_j_i,
    input  logic             is_jr_i,
    input  logic             is_eret_i,
    input  logic             exc_req_i,
    input  logic [4:0]       exc_code_i,
    input  logic [29:0]      exc_pc_i,
    input  logic [IRQ_W-1:0] int_req_i,
    input  logic             cp0_we_i,
    input  logic [4:0]       cp0_addr_i,
    input  logic [31:0]      cp0_wdata_i,
`ifdef EXC_BD_EN
    input  logic             in_delay_slot_i,
`endif
    output logic [31:0]      cp0_rdata_o,
    output logic [2:0]       pc_source_o,
    output logic [29:0]      epc_out_o,
    output logic             flush_o,
    output logic             exl_o
);

    state_e           state_q;
    pc_src_e          pc_src;
    logic             flush;
    logic             exc_take;
    logic             eret_fire;
    logic             cp0_wr;
    logic             int_pend;
    logic             ie, exl;
    logic [IRQ_W-1:0] im, ip;
    logic [29:0]      epc;
    logic [4:0]       take_code;

    assign int_pend  = (|(ip & im)) & ie & ~exl;
    assign take_code = exc_req_i ? exc_code_i : EXC_INT;

    always_comb begin
        pc_src    = PC_NORMAL;
        flush     = 1'b0;
        exc_take  = 1'b0;
        eret_fire = 1'b0;
        cp0_wr    = 1'b0;
        if (state_q == StFlush) begin
            flush = 1'b1;
        end else if (exc_req_i || int_pend) begin
            // Exceptions are taken even under stall.
            exc_take = 1'b1;
            pc_src   = PC_ERROR;
            flush    = 1'b1;
            cp0_wr   = cp0_we_i;
        end else if (!stall_i) begin
            cp0_wr = cp0_we_i;
            if (is_eret_i) begin
                eret_fire = 1'b1;
                pc_src    = PC_EPC;
                flush     = 1'b1;
            end else if (is_jr_i) begin
                pc_src = PC_JR;
            end else if (is_j_i) begin
                pc_src = PC_J;
            end else if (branch_taken_i) begin
                pc_src = PC_ADD;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            unique case (state_q)
                StRun:   state_q <= exc_take ? StFlush : StRun;
                StFlush: state_q <= StRun;
                default: state_q <= StRun;
            endcase
        end
    end

    exc_pc_ctrl_cp0_regs u_cp0_regs (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .int_req_i       (int_req_i),
        .wr_en_i         (cp0_wr),
        .addr_i          (cp0_addr_i),
        .wdata_i         (cp0_wdata_i),
        .exc_take_i      (exc_take),
        .exc_code_i      (take_code),
        .exc_pc_i        (exc_pc_i),
`ifdef EXC_BD_EN
        .in_delay_slot_i (in_delay_slot_i),
`endif
        .eret_i          (eret_fire),
        .rdata_o         (cp0_rdata_o),
        .ie_o            (ie),
        .exl_o           (exl),
        .im_o            (im),
        .ip_o            (ip),
        .epc_o           (epc)
    );

    assign pc_source_o = pc_src;
    assign flush_o     = flush;
    assign exl_o       = exl;
    assign epc_out_o   = epc;

endmodule

// File: tb/tb_exc_pc_ctrl.sv
// Scoreboard bench for exc_pc_ctrl: per-cycle expectations queued at drive, checked at negedge.
module tb_exc_pc_ctrl;
    import exc_pc_ctrl_pkg::*;

    typedef struct packed {
        logic        rst, stall, br, j, jr, eret, exc;
        logic [4:0]  code;
        logic [29:0] xpc;
        logic [5:0]  irq;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        ds;
    } in_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [2:0]  pc;
        logic        fl;
        logic        exl;
        logic [31:0] rd;
        logic [29:0] epc;
    } exp_t;

    logic        clk = 1'b0;
    in_t         drv;
    logic [31:0] cp0_rdata;
    logic [2:0]  pc_source;
    logic [29:0] epc_out;
    logic        flush;
    logic        exl;

    exp_t        sb[$];
    exp_t        cur;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_step = 0;

    always #5 clk = ~clk;

    exc_pc_ctrl dut (
        .clk_i           (clk),
        .rst_i           (drv.rst),
        .stall_i         (drv.stall),
        .branch_taken_i  (drv.br),
        .is_j_i          (drv.j),
        .is_jr_i         (drv.jr),
        .is_eret_i       (drv.eret),
        .exc_req_i       (drv.exc),
        .exc_code_i      (drv.code),
        .exc_pc_i        (drv.xpc),
        .int_req_i       (drv.irq),
        .cp0_we_i        (drv.we),
        .cp0_addr_i      (drv.addr),
        .cp0_wdata_i     (drv.wd),
`ifdef EXC_BD_EN
        .in_delay_slot_i (drv.ds),
`endif
        .cp0_rdata_o     (cp0_rdata),
        .pc_source_o     (pc_source),
        .epc_out_o       (epc_out),
        .flush_o         (flush),
        .exl_o           (exl)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, want);
    endtask

    function automatic in_t idle();
        in_t i;
        i = '0;
        return i;
    endfunction

    function automatic exp_t ex(input logic [2:0] pc, input logic fl, input logic xl,
                                input logic [31:0] rd, input logic [29:0] ep);
        exp_t e;
        e.idx = '0;
        e.pc  = pc;
        e.fl  = fl;
        e.exl = xl;
        e.rd  = rd;
        e.epc = ep;
        return e;
    endfunction

    task automatic step(input in_t i, input exp_t e);
        @(posedge clk);
        #1;
        drv = i;
        n_step++;
        e.idx = 8'(n_step);
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            chk($sformatf("s%0d.pc_source", cur.idx), 32'(pc_source), 32'(cur.pc));
            chk($sformatf("s%0d.flush", cur.idx), 32'(flush), 32'(cur.fl));
            chk($sformatf("s%0d.exl", cur.idx), 32'(exl), 32'(cur.exl));
            chk($sformatf("s%0d.cp0_rdata", cur.idx), cp0_rdata, cur.rd);
            chk($sformatf("s%0d.epc_out", cur.idx), 32'(epc_out), 32'(cur.epc));
        end
    end

    initial begin
        in_t i;
        drv = idle();
        drv.rst = 1'b1;

        i = idle(); i.rst = 1'b1; i.addr = CP0_EPC;
        step(i, ex(0, 0, 0, 32'h0, 30'h0));
        i = idle(); i.addr = CP0_STATUS;
        step(i, ex(0, 0, 0, 32'h0, 30'h0));
        // Overflow exception, then a masked request during FLUSH.
        i = idle(); i.exc = 1; i.code = EXC_OV; i.xpc = 30'h100; i.addr = CP0_CAUSE;
        step(i, ex(5, 1, 0, 32'h0, 30'h0));
        i = idle(); i.exc = 1; i.code = EXC_RI; i.xpc = 30'h300; i.addr = CP0_EPC;
        step(i, ex(0, 1, 1, 32'h400, 30'h100));
        i = idle(); i.addr = CP0_CAUSE;
        step(i, ex(0, 0, 1, 32'h30, 30'h100));
        // Nested exception keeps EPC.
        i = idle(); i.exc = 1; i.code = EXC_SYS; i.xpc = 30'h200; i.addr = CP0_EPC;
        step(i, ex(5, 1, 1, 32'h400, 30'h100));
        i = idle(); i.addr = CP0_CAUSE;
        step(i, ex(0, 1, 1, 32'h20, 30'h100));
        i = idle(); i.eret = 1; i.addr = CP0_EPC;
        step(i, ex(4, 1, 1, 32'h400, 30'h100));
        i = idle(); i.addr = CP0_STATUS;
        step(i, ex(0, 0, 0, 32'h0, 30'h100));
        // Interrupt enable via mtc0, interrupt taken one cycle later.
        i = idle(); i.we = 1; i.addr = CP0_STATUS; i.wd = 32'h0000_0401; i.irq = 6'h01;
        step(i, ex(0, 0, 0, 32'h0, 30'h100));
        i = idle(); i.irq = 6'h01; i.xpc = 30'h050; i.addr = CP0_STATUS;
        step(i, ex(5, 1, 0, 32'h401, 30'h100));
        i = idle(); i.irq = 6'h01; i.addr = CP0_CAUSE;
        step(i, ex(0, 1, 1, 32'h400, 30'h050));
        i = idle(); i.irq = 6'h01; i.addr = CP0_STATUS;
        step(i, ex(0, 0, 1, 32'h403, 30'h050));
        i = idle(); i.irq = 6'h01; i.we = 1; i.addr = CP0_STATUS; i.wd = 32'h0000_0400;
        step(i, ex(0, 0, 1, 32'h403, 30'h050));
        i = idle(); i.irq = 6'h01; i.addr = CP0_STATUS;
        step(i, ex(0, 0, 0, 32'h400, 30'h050));
        // Jump/branch priority, stall, and exception under stall.
        i = idle(); i.br = 1; i.j = 1; i.jr = 1;
        step(i, ex(3, 0, 0, 32'h0, 30'h050));
        i.stall = 1;
        step(i, ex(0, 0, 0, 32'h0, 30'h050));
        i.exc = 1; i.code = EXC_OV; i.xpc = 30'h077; i.addr = CP0_EPC;
        step(i, ex(5, 1, 0, 32'h140, 30'h050));
        i = idle(); i.j = 1; i.addr = CP0_EPC;
        step(i, ex(0, 1, 1, 32'h1dc, 30'h077));
        i = idle(); i.j = 1; i.addr = CP0_CAUSE;
        step(i, ex(2, 0, 1, 32'h30, 30'h077));
        i = idle(); i.br = 1; i.addr = CP0_STATUS;
        step(i, ex(1, 0, 1, 32'h402, 30'h077));
        // Stalled eret and mtc0 are deferred.
        i = idle(); i.eret = 1; i.stall = 1; i.we = 1; i.addr = CP0_EPC; i.wd = 32'h1234;
        step(i, ex(0, 0, 1, 32'h1dc, 30'h077));
        i = idle(); i.eret = 1; i.we = 1; i.addr = CP0_EPC; i.wd = 32'h1238;
        step(i, ex(4, 1, 1, 32'h1dc, 30'h077));
        i = idle(); i.addr = CP0_EPC;
        step(i, ex(0, 0, 0, 32'h1238, 30'h48e));
        i = idle(); i.we = 1; i.addr = 5'd5; i.wd = 32'hffff_ffff;
        step(i, ex(0, 0, 0, 32'h0, 30'h48e));
        // mtc0 Status coinciding with an exception.
        i = idle(); i.exc = 1; i.code = EXC_RI; i.xpc = 30'h010;
        i.we = 1; i.addr = CP0_STATUS; i.wd = 32'h0000_0002;
        step(i, ex(5, 1, 0, 32'h400, 30'h48e));
        i = idle(); i.addr = CP0_STATUS;
        step(i, ex(0, 1, 1, 32'h2, 30'h010));
        // Reset mid-run while EXL=1.
        i = idle(); i.rst = 1; i.addr = CP0_EPC;
        step(i, ex(0, 0, 0, 32'h0, 30'h0));
        i = idle(); i.addr = CP0_CAUSE;
        step(i, ex(0, 0, 0, 32'h0, 30'h0));
`ifdef EXC_BD_EN
        i = idle(); i.exc = 1; i.code = EXC_OV; i.xpc = 30'h101; i.ds = 1; i.addr = CP0_CAUSE;
        step(i, ex(5, 1, 0, 32'h0, 30'h0));
        i = idle(); i.addr = CP0_CAUSE;
        step(i, ex(0, 1, 1, 32'h8000_0030, 30'h100));
`endif
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
